cell_response_checker: RTL and testbench

//  Synthesizable far end of the exhaustive cell test: drives every input vector into a

---
 rtl/cell_chk_pkg.sv | 28 ++
 rtl/cell_response_checker.sv | 124 ++++++++++++
 tb/tb_cell_response_checker.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cell_chk_pkg.sv
// Shared definitions for the standard-cell exhaustive response checker.
// Holds the checker state encoding and reference truth tables for common
// cells. Truth tables are indexed by input vector v: bit v is the expected
// output when the cell inputs equal v, with the first-named pin as MSB.
package cell_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    REPORT,
    DONE
  } chk_state_t;

  // ZN = !(A1&A2 | B1&B2 | C1&C2), vector {A1,A2,B1,B2,C1,C2}
  localparam logic [63:0] AOI222_TRUTH = 64'h0000_0777_0777_0777;
  // ZN = !((A1|A2) & (B1|B2) & (C1|C2)), vector {A1,A2,B1,B2,C1,C2}
  localparam logic [63:0] OAI222_TRUTH = 64'h111F_111F_111F_FFFF;
  // ZN = !(A1&A2 | B1&B2), vector {A1,A2,B1,B2}
  localparam logic [15:0] AOI22_TRUTH  = 16'h0777;
  // ZN = !((A1|A2) & (B1|B2)), vector {A1,A2,B1,B2}
  localparam logic [15:0] OAI22_TRUTH  = 16'h111F;
  // ZN = !(A1&A2 | B), vector {A1,A2,B}
  localparam logic [7:0]  AOI21_TRUTH  = 8'h15;
  // ZN = !((A1|A2) & B), vector {A1,A2,B}
  localparam logic [7:0]  OAI21_TRUTH  = 8'h57;

endpackage

// File: rtl/cell_response_checker.sv
// Exhaustive truth-table checker for a single-output standard cell.
// Walks every input vector, holds each for SETTLE cycles, samples the cell
// output, compares against TRUTH and streams mismatch records out over a
// valid/ready port while counting failures.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   start                begin a sweep (accepted only when idle or done)
//   stim, stim_valid     vector driven to the cell and its qualifier
//   dut_out              cell output under test
//   mis_valid/ready      mismatch record handshake; mis_vec, mis_got payload
//   busy, done, pass     sweep status; pass valid while done
//   err_count            mismatching vectors in the current sweep
module cell_response_checker
  import cell_chk_pkg::*;
#(
  parameter int                    NUM_IN = 6,
  parameter int                    SETTLE = 2,
  parameter logic [2**NUM_IN-1:0]  TRUTH  = AOI222_TRUTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [NUM_IN-1:0] stim,
  output logic              stim_valid,
  input  logic              dut_out,
  output logic              mis_valid,
  input  logic              mis_ready,
  output logic [NUM_IN-1:0] mis_vec,
  output logic              mis_got,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [NUM_IN:0]   err_count
);

  localparam int                CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]     SETTLE_LOAD = CW'(SETTLE - 1);
  localparam logic [NUM_IN-1:0] LAST_VEC    = '1;

  chk_state_t        state_reg;
  logic [NUM_IN-1:0] vec_reg;
  logic [CW-1:0]     settle_reg;
  logic              sample_match;
  logic              advance;

  // Case equality so an X/Z output in simulation is never taken as a match.
  assign sample_match = (dut_out === TRUTH[vec_reg]);

  // Move past the current vector: a clean sample, or a record just accepted.
  assign advance = ((state_reg == SAMPLE) && sample_match) ||
                   ((state_reg == REPORT) && mis_ready);

  assign stim = vec_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      vec_reg    <= '0;
      settle_reg <= '0;
      stim_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      mis_valid  <= 1'b0;
      mis_vec    <= '0;
      mis_got    <= 1'b0;
      err_count  <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg  <= DRIVE;
            vec_reg    <= '0;
            settle_reg <= SETTLE_LOAD;
            stim_valid <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
          end
        end
        DRIVE: begin
          if (settle_reg == '0) begin
            state_reg <= SAMPLE;
          end else begin
            settle_reg <= settle_reg - 1'b1;
          end
        end
        SAMPLE: begin
          if (!sample_match) begin
            err_count <= err_count + 1'b1;
            mis_vec   <= vec_reg;
            // Anything that is not a clean 0 is reported as 1.
            mis_got   <= (dut_out === 1'b0) ? 1'b0 : 1'b1;
            mis_valid <= 1'b1;
            state_reg <= REPORT;
          end
        end
        REPORT: begin
          if (mis_ready) begin
            mis_valid <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (advance) begin
        if (vec_reg == LAST_VEC) begin
          state_reg  <= DONE;
          stim_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b1;
          // err_count never changes on an advancing cycle, so it is final here.
          pass       <= (err_count == '0);
        end else begin
          vec_reg    <= vec_reg + 1'b1;
          settle_reg <= SETTLE_LOAD;
          state_reg  <= DRIVE;
        end
      end
    end
  end

endmodule

// File: tb/tb_cell_response_checker.sv
module tb_cell_response_checker;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] stim;
  logic       stim_valid;
  logic       dut_out;
  logic       mis_valid;
  logic       mis_ready;
  logic [5:0] mis_vec;
  logic       mis_got;
  logic       busy;
  logic       done;
  logic       pass;
  logic [6:0] err_count;
  logic       stuck1;

  logic       start4;
  logic [3:0] stim4;
  logic       stim_valid4;
  logic       dut_out4;
  logic       mis_valid4;
  logic       mis_ready4;
  logic [3:0] mis_vec4;
  logic       mis_got4;
  logic       busy4;
  logic       done4;
  logic       pass4;
  logic [4:0] err4;
  logic       stuck0_4;
  logic [15:0] tbl4;

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell models: AOI222 written as its boolean equation, 4-input cell as a table.
  assign dut_out  = stuck1 ? 1'b1 :
                    ~((stim[5] & stim[4]) | (stim[3] & stim[2]) | (stim[1] & stim[0]));
  assign dut_out4 = stuck0_4 ? 1'b0 : tbl4[stim4];

  cell_response_checker u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stim       (stim),
    .stim_valid (stim_valid),
    .dut_out    (dut_out),
    .mis_valid  (mis_valid),
    .mis_ready  (mis_ready),
    .mis_vec    (mis_vec),
    .mis_got    (mis_got),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count)
  );

  cell_response_checker #(
    .NUM_IN (4),
    .SETTLE (1),
    .TRUTH  (16'h7770)
  ) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .start      (start4),
    .stim       (stim4),
    .stim_valid (stim_valid4),
    .dut_out    (dut_out4),
    .mis_valid  (mis_valid4),
    .mis_ready  (mis_ready4),
    .mis_vec    (mis_vec4),
    .mis_got    (mis_got4),
    .busy       (busy4),
    .done       (done4),
    .pass       (pass4),
    .err_count  (err4)
  );

  // Pulse start and follow the sweep until busy drops, collecting record stats.
  // Optionally holds start high while stim equals pulse_vec.
  task automatic run_sweep(input int pulse_vec, output int cycles, output int recs,
                           output logic [5:0] fv, output logic fg, output logic [5:0] lv);
    cycles = 0;
    recs   = 0;
    fv     = '0;
    fg     = 1'b0;
    lv     = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (busy && cycles < 2000) begin
      cycles++;
      if (mis_valid && mis_ready) begin
        if (recs == 0) begin
          fv = mis_vec;
          fg = mis_got;
        end
        lv = mis_vec;
        recs++;
      end
      start = (pulse_vec >= 0) && (int'(stim) == pulse_vec);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({stim, stim_valid, mis_valid, mis_vec, mis_got, busy, done, pass, err_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got stim=%0d sv=%0b mv=%0b busy=%0b done=%0b pass=%0b err=%0d required all 0",
               stim, stim_valid, mis_valid, busy, done, pass, err_count);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, stim_valid} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%0b done=%0b sv=%0b required 0", busy, done, stim_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_good_sweep(input string tag);
    int cyc, recs;
    logic [5:0] fv, lv;
    logic fg;
    stuck1 = 1'b0;
    run_sweep(-1, cyc, recs, fv, fg, lv);
    checks++;
    if (cyc !== 192) begin
      failures++;
      $display("FAIL %s_cycles got %0d required 192", tag, cyc);
    end
    checks++;
    if ({done, pass, busy} !== 3'b110) begin
      failures++;
      $display("FAIL %s_status got done=%0b pass=%0b busy=%0b required 1 1 0", tag, done, pass, busy);
    end
    checks++;
    if (err_count !== 7'd0) begin
      failures++;
      $display("FAIL %s_err got %0d required 0", tag, err_count);
    end
    checks++;
    if (recs !== 0) begin
      failures++;
      $display("FAIL %s_records got %0d required 0", tag, recs);
    end
    $display("%s sweep cycles=%0d err=%0d pass=%0b", tag, cyc, err_count, pass);
  endtask

  task automatic test_stuck1();
    int cyc, recs;
    logic [5:0] fv, lv;
    logic fg;
    stuck1    = 1'b1;
    mis_ready = 1'b1;
    run_sweep(-1, cyc, recs, fv, fg, lv);
    checks++;
    if (err_count !== 7'd37 || recs !== 37) begin
      failures++;
      $display("FAIL stuck1_err got err=%0d recs=%0d required 37 37", err_count, recs);
    end
    checks++;
    if ({done, pass} !== 2'b10) begin
      failures++;
      $display("FAIL stuck1_status got done=%0b pass=%0b required 1 0", done, pass);
    end
    checks++;
    if (fv !== 6'b000011 || fg !== 1'b1) begin
      failures++;
      $display("FAIL stuck1_first got vec=%b got=%0b required 000011 1", fv, fg);
    end
    checks++;
    if (lv !== 6'b111111) begin
      failures++;
      $display("FAIL stuck1_last got %b required 111111", lv);
    end
    checks++;
    if (cyc !== 229) begin
      failures++;
      $display("FAIL stuck1_cycles got %0d required 229", cyc);
    end
    $display("stuck1 sweep cycles=%0d err=%0d first=%b last=%b", cyc, err_count, fv, lv);
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    stuck1    = 1'b1;
    mis_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!mis_valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (mis_valid !== 1'b1 || mis_vec !== 6'b000011 || mis_got !== 1'b1) begin
      failures++;
      $display("FAIL bp_first_record got mv=%0b vec=%b got=%0b required 1 000011 1", mis_valid, mis_vec, mis_got);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (stim !== 6'd3 || mis_valid !== 1'b1 || mis_vec !== 6'd3 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL bp_hold got %0d bad cycles (last stim=%0d mv=%0b) required 0", bad, stim, mis_valid);
    end
    mis_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (stim !== 6'd4 || mis_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_resume got stim=%0d mv=%0b required 4 0", stim, mis_valid);
    end
    n = 0;
    while (busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (err_count !== 7'd37 || done !== 1'b1) begin
      failures++;
      $display("FAIL bp_final got err=%0d done=%0b required 37 1", err_count, done);
    end
    $display("backpressure sweep err=%0d", err_count);
  endtask

  task automatic test_reset_mid();
    int n;
    stuck1 = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (stim !== 6'd20 && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (stim !== 6'd20) begin
      failures++;
      $display("FAIL mid_reach20 got stim=%0d required 20", stim);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({stim, stim_valid, mis_valid, mis_vec, mis_got, busy, done, pass, err_count} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs got stim=%0d sv=%0b busy=%0b done=%0b err=%0d required all 0",
               stim, stim_valid, busy, done, err_count);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("reset mid-sweep applied at stim=20");
    test_good_sweep("after_reset");
  endtask

  task automatic test_ignored_start();
    int cyc, recs, n;
    logic [5:0] fv, lv;
    logic fg;
    stuck1    = 1'b1;
    mis_ready = 1'b1;
    run_sweep(5, cyc, recs, fv, fg, lv);
    checks++;
    if (cyc !== 229 || err_count !== 7'd37 || recs !== 37) begin
      failures++;
      $display("FAIL ign_start_sweep got cycles=%0d err=%0d recs=%0d required 229 37 37", cyc, err_count, recs);
    end
    stuck1 = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (err_count !== 7'd0 || pass !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_clear got err=%0d pass=%0b done=%0b busy=%0b required 0 0 0 1",
               err_count, pass, done, busy);
    end
    n = 0;
    while (busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (pass !== 1'b1 || done !== 1'b1 || err_count !== 7'd0) begin
      failures++;
      $display("FAIL restart_pass got pass=%0b done=%0b err=%0d required 1 1 0", pass, done, err_count);
    end
    $display("restart sweep err=%0d pass=%0b", err_count, pass);
  endtask

  task automatic test_small_cell();
    int cyc, bad, recs;
    logic [3:0] fv;
    logic fg;
    // Clean run: vector k is on stim for cycles 2k and 2k+1.
    stuck0_4 = 1'b0;
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    cyc = 0;
    bad = 0;
    while (busy4 && cyc < 500) begin
      if (int'(stim4) != cyc / 2) bad++;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc !== 32 || bad !== 0) begin
      failures++;
      $display("FAIL small_timing got cycles=%0d bad_stim=%0d required 32 0", cyc, bad);
    end
    checks++;
    if ({done4, pass4} !== 2'b11 || err4 !== 5'd0) begin
      failures++;
      $display("FAIL small_pass got done=%0b pass=%0b err=%0d required 1 1 0", done4, pass4, err4);
    end
    // Stuck-at-0 fails every vector whose expected output is 1.
    stuck0_4 = 1'b1;
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    cyc  = 0;
    recs = 0;
    fv   = '0;
    fg   = 1'b1;
    while (busy4 && cyc < 500) begin
      if (mis_valid4 && mis_ready4) begin
        if (recs == 0) begin
          fv = mis_vec4;
          fg = mis_got4;
        end
        recs++;
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc !== 41 || err4 !== 5'd9 || pass4 !== 1'b0) begin
      failures++;
      $display("FAIL small_stuck0 got cycles=%0d err=%0d pass=%0b required 41 9 0", cyc, err4, pass4);
    end
    checks++;
    if (fv !== 4'd4 || fg !== 1'b0) begin
      failures++;
      $display("FAIL small_first got vec=%0d got=%0b required 4 0", fv, fg);
    end
    $display("small cell sweeps err=%0d", err4);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    start      = 1'b0;
    mis_ready  = 1'b1;
    stuck1     = 1'b0;
    start4     = 1'b0;
    mis_ready4 = 1'b1;
    stuck0_4   = 1'b0;
    tbl4       = 16'h7770;

    test_reset();
    test_good_sweep("good");
    test_stuck1();
    test_backpressure();
    test_reset_mid();
    test_ignored_start();
    test_small_cell();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
